// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, muldiv FSM states and opcode decode helpers
package alu_pkg;

  localparam int OP_BITS = 5;
  typedef logic [OP_BITS-1:0] opcode_t;

  localparam opcode_t OP_SLL   = 5'd0;
  localparam opcode_t OP_SRL   = 5'd1;
  localparam opcode_t OP_SRA   = 5'd2;
  localparam opcode_t OP_ADD   = 5'd3;
  localparam opcode_t OP_SUB   = 5'd4;
  localparam opcode_t OP_AND   = 5'd5;
  localparam opcode_t OP_OR    = 5'd6;
  localparam opcode_t OP_XOR   = 5'd7;
  localparam opcode_t OP_NOR   = 5'd8;
  localparam opcode_t OP_SLT   = 5'd9;
  localparam opcode_t OP_SLTU  = 5'd10;
  localparam opcode_t OP_LUI   = 5'd11;
  localparam opcode_t OP_MFHI  = 5'd12;
  localparam opcode_t OP_MFLO  = 5'd13;
  localparam opcode_t OP_MTHI  = 5'd14;
  localparam opcode_t OP_MTLO  = 5'd15;
  localparam opcode_t OP_MULT  = 5'd16;
  localparam opcode_t OP_MULTU = 5'd17;
  localparam opcode_t OP_DIV   = 5'd18;
  localparam opcode_t OP_DIVU  = 5'd19;
  localparam opcode_t OP_NONE  = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv_op(opcode_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  // Any op that reads or writes HI/LO must wait for the iterative unit.
  function automatic logic is_hilo_op(opcode_t op);
    return is_muldiv_op(op) || (op inside {OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider with HI/LO
// Magnitudes are processed unsigned; signs are reapplied on the final step.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_div,
  input  logic                  is_signed,
  input  logic                  wr_hi,
  input  logic                  wr_lo,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  md_state_t          state, state_nx;
  logic [CNT_W-1:0]   count;
  logic [W-1:0]       acc_hi, acc_lo, opnd;
  logic               div_mode, neg_q, neg_r, div_zero;
  logic               a_neg, b_neg, last_step;
  logic [W-1:0]       a_mag, b_mag;
  logic [W:0]         mul_sum, div_shift;
  logic               div_ge;
  logic [W-1:0]       step_hi, step_lo;
  logic [2*W-1:0]     product, prod_fix;
  logic [W-1:0]       res_hi, res_lo;

  assign a_neg     = is_signed && op_a[W-1];
  assign b_neg     = is_signed && op_b[W-1];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;
  assign last_step = (count == CNT_W'(W-1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Multiply: acc_hi = partial product, acc_lo = multiplier shifting out.
  // Divide:   acc_hi = partial remainder, acc_lo = dividend in / quotient out.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    if (div_mode) begin
      step_hi = div_ge ? (div_shift[W-1:0] - opnd) : div_shift[W-1:0];
      step_lo = {acc_lo[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end
  end

  // Divide by zero yields quotient all ones and remainder |a|; re-signing
  // that remainder restores the raw dividend.
  always_comb begin
    product  = {step_hi, step_lo};
    prod_fix = neg_q ? -product : product;
    if (div_mode) begin
      res_lo = div_zero ? '1 : (neg_q ? -step_lo : step_lo);
      res_hi = neg_r ? -step_hi : step_hi;
    end else begin
      res_hi = prod_fix[2*W-1:W];
      res_lo = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            opnd     <= b_mag;
            div_mode <= is_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= is_div && a_neg;
            div_zero <= is_div && (op_b == '0);
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
          if (last_step) begin
            count <= '0;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - EX-stage ALU with iterative MULT/DIV and HI/LO registers
// Optional ALU_MULDIV_OVERFLOW_EN adds o_overflow for signed ADD/SUB overflow.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5,
  parameter int SHAMT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_op_valid,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [DATA_WIDTH-1:0]   i_data1,
  input  logic [DATA_WIDTH-1:0]   i_data2,
  output logic [DATA_WIDTH-1:0]   o_result,
  output logic                    o_zero,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_stall,
  output logic [DATA_WIDTH-1:0]   o_hi,
  output logic [DATA_WIDTH-1:0]   o_lo
`ifdef ALU_MULDIV_OVERFLOW_EN
  ,
  output logic                    o_overflow
`endif
);

  localparam int OPW = (OPCODE_WIDTH > OP_BITS) ? OPCODE_WIDTH : OP_BITS;
  localparam int MSB = DATA_WIDTH - 1;

  logic [OPW-1:0]         opcode_ext;
  opcode_t                op;
  logic                   accept, md_start, md_div, md_signed;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  sum, diff;

  // Codes with bits set above the package width decode as unlisted.
  assign opcode_ext = OPW'(i_opcode);
  assign op = ((opcode_ext >> OP_BITS) == '0) ? opcode_ext[OP_BITS-1:0] : OP_NONE;

  assign accept    = i_op_valid && !o_busy;
  assign md_start  = accept && is_muldiv_op(op);
  assign md_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign md_signed = (op == OP_MULT) || (op == OP_DIV);
  assign o_stall   = i_op_valid && o_busy && is_hilo_op(op);

  muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .start     (md_start),
    .is_div    (md_div),
    .is_signed (md_signed),
    .wr_hi     (accept && (op == OP_MTHI)),
    .wr_lo     (accept && (op == OP_MTLO)),
    .wr_data   (i_data1),
    .op_a      (i_data1),
    .op_b      (i_data2),
    .busy      (o_busy),
    .done      (o_done),
    .hi        (o_hi),
    .lo        (o_lo)
  );

  assign shamt = i_data1[SHAMT_WIDTH-1:0];
  assign sum   = i_data1 + i_data2;
  assign diff  = i_data1 - i_data2;

  always_comb begin
    o_result = '0;
    case (op)
      OP_SLL:  o_result = i_data2 << shamt;
      OP_SRL:  o_result = i_data2 >> shamt;
      OP_SRA:  o_result = $unsigned($signed(i_data2) >>> shamt);
      OP_ADD:  o_result = sum;
      OP_SUB:  o_result = diff;
      OP_AND:  o_result = i_data1 & i_data2;
      OP_OR:   o_result = i_data1 | i_data2;
      OP_XOR:  o_result = i_data1 ^ i_data2;
      OP_NOR:  o_result = ~(i_data1 | i_data2);
      OP_SLT:  o_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_data1) < $signed(i_data2))};
      OP_SLTU: o_result = {{(DATA_WIDTH-1){1'b0}}, (i_data1 < i_data2)};
      OP_LUI:  o_result = i_data2 << (DATA_WIDTH / 2);
      OP_MFHI: o_result = o_hi;
      OP_MFLO: o_result = o_lo;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

`ifdef ALU_MULDIV_OVERFLOW_EN
  always_comb begin
    o_overflow = 1'b0;
    if (op == OP_ADD)
      o_overflow = (i_data1[MSB] == i_data2[MSB]) && (sum[MSB] != i_data1[MSB]);
    else if (op == OP_SUB)
      o_overflow = (i_data1[MSB] != i_data2[MSB]) && (diff[MSB] != i_data1[MSB]);
  end
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv at DATA_WIDTH = 32
module tb_alu_muldiv;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        stall;
    logic        chk_res;
    logic        ovf;
  } comb_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_op_valid = 1'b0;
  logic [4:0]  i_opcode = '0;
  logic [31:0] i_data1 = '0;
  logic [31:0] i_data2 = '0;
  logic [31:0] o_result, o_hi, o_lo;
  logic        o_zero, o_busy, o_done, o_stall;
`ifdef ALU_MULDIV_OVERFLOW_EN
  logic        o_overflow;
`endif

  int    n_checks = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  comb_t q_c[$];
  md_t   q_md[$];

  alu_muldiv #(
    .DATA_WIDTH(32),
    .OPCODE_WIDTH(5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_op_valid (i_op_valid),
    .i_opcode   (i_opcode),
    .i_data1    (i_data1),
    .i_data2    (i_data2),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_stall    (o_stall),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
`ifdef ALU_MULDIV_OVERFLOW_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic comb_t ce(input string n, input logic [31:0] r, input logic st = 1'b0,
                               input logic chk = 1'b1, input logic ov = 1'b0);
    comb_t e;
    e.name = n; e.res = r; e.stall = st; e.chk_res = chk; e.ovf = ov;
    return e;
  endfunction

  // Combinational monitor: one expected entry per presented op.
  always @(negedge clock) begin
    comb_t e;
    if (!reset && i_op_valid) begin
      check("comb_queue_has_entry", 32'(q_c.size() != 0), 32'd1);
      if (q_c.size() != 0) begin
        e = q_c.pop_front();
        if (e.chk_res) begin
          check({e.name, "_result"}, o_result, e.res);
          check({e.name, "_zero"}, 32'(o_zero), 32'(e.res == 32'd0));
        end
        check({e.name, "_stall"}, 32'(o_stall), 32'(e.stall));
`ifdef ALU_MULDIV_OVERFLOW_EN
        check({e.name, "_overflow"}, 32'(o_overflow), 32'(e.ovf));
`endif
      end
    end
  end

  // HI/LO monitor: pops on every o_done pulse.
  always @(negedge clock) begin
    md_t m;
    if (!reset && o_done) begin
      done_cnt++;
      check("md_queue_has_entry", 32'(q_md.size() != 0), 32'd1);
      if (q_md.size() != 0) begin
        m = q_md.pop_front();
        check({m.name, "_hi"}, o_hi, m.hi);
        check({m.name, "_lo"}, o_lo, m.lo);
      end
    end
  end

  task automatic present(input opcode_t op, input logic [31:0] a, input logic [31:0] b, input comb_t e);
    @(posedge clock);
    #1;
    i_op_valid = 1'b1;
    i_opcode   = op;
    i_data1    = a;
    i_data2    = b;
    q_c.push_back(e);
    @(posedge clock);
    #1;
    i_op_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the acceptance edge.
  task automatic wait_done(input string n, output int cyc);
    bit got;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      cyc++;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    check({n, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run_md(input string n, input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    md_t m;
    int  cyc;
    m.name = n; m.hi = hi; m.lo = lo;
    q_md.push_back(m);
    present(op, a, b, ce({n, "_issue"}, 32'd0, 1'b0, 1'b0));
    wait_done(n, cyc);
    check({n, "_latency"}, 32'(cyc), 32'd33);
  endtask

  initial begin
    int cyc;
    int d0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_hi", o_hi, 32'd0);
    check("reset_lo", o_lo, 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    present(OP_SRA,  32'h0000_0024, 32'h8000_0000, ce("sra",  32'hF800_0000));
    present(OP_SLL,  32'd31,        32'd1,         ce("sll",  32'h8000_0000));
    present(OP_SRL,  32'd4,         32'h8000_0000, ce("srl",  32'h0800_0000));
    present(OP_ADD,  32'd5,         32'd3,         ce("add",  32'd8));
    present(OP_SUB,  32'd3,         32'd3,         ce("sub_zero", 32'd0));
    present(OP_AND,  32'h0000_F0F0, 32'h0000_FF00, ce("and",  32'h0000_F000));
    present(OP_OR,   32'h0000_F0F0, 32'h0000_FF00, ce("or",   32'h0000_FFF0));
    present(OP_XOR,  32'h0000_F0F0, 32'h0000_FF00, ce("xor",  32'h0000_0FF0));
    present(OP_NOR,  32'd0,         32'd0,         ce("nor",  32'hFFFF_FFFF));
    present(OP_SLT,  32'hFFFF_FFFF, 32'd1,         ce("slt",  32'd1));
    present(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         ce("sltu_big", 32'd0));
    present(OP_SLTU, 32'd1,         32'hFFFF_FFFF, ce("sltu_small", 32'd1));
    present(OP_LUI,  32'd0,         32'h0000_ABCD, ce("lui",  32'hABCD_0000));
    present(5'd31,   32'd5,         32'd5,         ce("unlisted", 32'd0));
`ifdef ALU_MULDIV_OVERFLOW_EN
    present(OP_ADD,  32'h7FFF_FFFF, 32'd1,         ce("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1));
    present(OP_SUB,  32'd5,         32'd3,         ce("sub_noovf", 32'd2, 1'b0, 1'b1, 1'b0));
    present(OP_SUB,  32'h8000_0000, 32'd1,         ce("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1));
`endif

    run_md("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE);
    run_md("mult_carry", OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    run_md("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Ops while busy: HI/LO ops stall and are ignored, ADD still executes.
    q_md.push_back('{name: "div_busy", hi: 32'd2, lo: 32'd14});
    present(OP_DIV,  32'd100, 32'd7, ce("div_busy_issue", 32'd0, 1'b0, 1'b0));
    present(OP_MFLO, 32'd0,   32'd0, ce("mflo_busy", 32'd0, 1'b1, 1'b0));
    present(OP_MULT, 32'd3,   32'd3, ce("mult_busy", 32'd0, 1'b1, 1'b0));
    check("busy_hi_held", o_hi, 32'hFFFF_FFFF);
    check("busy_lo_held", o_lo, 32'hFFFF_FFFD);
    check("busy_flag", 32'(o_busy), 32'd1);
    present(OP_ADD,  32'd2,   32'd2, ce("add_busy", 32'd4));
    wait_done("div_busy", cyc);

    run_md("div_minneg", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_md("div_zero_s", OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_md("divu_big",   OP_DIVU, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999);
    run_md("divu_zero",  OP_DIVU, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);

    // Abort in RUN cycle 10: no o_done may follow.
    present(OP_MULT, 32'd3, 32'd5, ce("mult_abort_issue", 32'd0, 1'b0, 1'b0));
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_hi", o_hi, 32'd0);
    check("abort_lo", o_lo, 32'd0);
    d0 = done_cnt;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clock);
    check("abort_no_done", 32'(done_cnt), 32'(d0));

    present(OP_MTHI, 32'hAAAA_5555, 32'd0, ce("mthi", 32'd0));
    present(OP_MFHI, 32'd0,         32'd0, ce("mfhi", 32'hAAAA_5555));
    present(OP_MTLO, 32'h1234_5678, 32'd0, ce("mtlo", 32'd0));
    present(OP_MFLO, 32'd0,         32'd0, ce("mflo", 32'h1234_5678));

    repeat (3) @(posedge clock);
    check("final_comb_queue", 32'(q_c.size()), 32'd0);
    check("final_md_queue", 32'(q_md.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
